// File: rtl/axis_protocol_monitor.sv
// Passive AXI4-Stream protocol monitor.
// Sticky per-rule error flags plus beat and packet statistics.
module axis_protocol_monitor #(
  parameter int C_AXIS_DATA_WIDTH = 128,
  parameter int C_AXIS_USER_WIDTH = 1,
  parameter int C_AXIS_DEST_WIDTH = 1,
  parameter int MAX_WAIT          = 16,
  parameter int MAX_PKT_BEATS     = 0,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           axis_tvalid,
  input  logic                           axis_tready,
  input  logic                           axis_tlast,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] axis_tkeep,
  input  logic [C_AXIS_USER_WIDTH-1:0]   axis_tuser,
  input  logic [C_AXIS_DEST_WIDTH-1:0]   axis_tdest,
  input  logic                           err_clear,
  output logic [6:0]                     err_flags,
  output logic                           err_any,
  output logic [CNT_WIDTH-1:0]           beat_count,
  output logic [CNT_WIDTH-1:0]           pkt_count,
  output logic                           in_packet
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int PW = $clog2(MAX_PKT_BEATS + 2);

  logic                         stall;
  logic                         hs;
  logic                         hold_r;
  logic                         armed_r;
  logic [C_AXIS_DATA_WIDTH-1:0] data_q;
  logic                         last_q;
  logic [KW-1:0]                keep_q;
  logic [C_AXIS_USER_WIDTH-1:0] user_q;
  logic [C_AXIS_DEST_WIDTH-1:0] dest_q;
  logic [WW-1:0]                wait_q;
  logic [PW-1:0]                beats_q;
  logic [6:0]                   viol;

  assign stall = axis_tvalid & ~axis_tready;
  assign hs    = axis_tvalid & axis_tready;

  // armed_r masks every rule in the first cycle after reset
  always_comb begin
    viol = '0;
    if (armed_r && hold_r) begin
      if (!axis_tvalid) begin
        viol[4] = 1'b1;
      end else begin
        viol[0] = axis_tdata != data_q;
        viol[1] = axis_tlast != last_q;
        viol[2] = axis_tkeep != keep_q;
        viol[3] = (axis_tuser != user_q) || (axis_tdest != dest_q);
      end
    end
    if (MAX_WAIT != 0 && armed_r && stall &&
        wait_q == WW'(MAX_WAIT - 1))
      viol[5] = 1'b1;
    if (MAX_PKT_BEATS != 0 && armed_r && hs &&
        beats_q == PW'(MAX_PKT_BEATS))
      viol[6] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (stall) begin
      data_q <= axis_tdata;
      last_q <= axis_tlast;
      keep_q <= axis_tkeep;
      user_q <= axis_tuser;
      dest_q <= axis_tdest;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      hold_r     <= 1'b0;
      armed_r    <= 1'b0;
      wait_q     <= '0;
      beats_q    <= '0;
      err_flags  <= '0;
      err_any    <= 1'b0;
      beat_count <= '0;
      pkt_count  <= '0;
      in_packet  <= 1'b0;
    end else begin
      hold_r  <= stall;
      armed_r <= 1'b1;
      if (!stall)
        wait_q <= '0;
      else if (wait_q != WW'(MAX_WAIT))
        wait_q <= wait_q + WW'(1);
      if (hs) begin
        beat_count <= beat_count + CNT_WIDTH'(1);
        if (axis_tlast) begin
          pkt_count <= pkt_count + CNT_WIDTH'(1);
          beats_q   <= '0;
          in_packet <= 1'b0;
        end else begin
          in_packet <= 1'b1;
          // saturate past the limit so a long packet flags only once
          if (beats_q != PW'(MAX_PKT_BEATS + 1))
            beats_q <= beats_q + PW'(1);
        end
      end
      err_flags <= (err_clear ? 7'd0 : err_flags) | viol;
      err_any   <= |err_flags;
    end
  end

endmodule
